// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C register-file target.
// Holds the FSM state type and the address-match helper.
package i2c_target_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RACK,
      ST_IGNORE
   } state_e;

   localparam int         BITS_PER_BYTE     = 8;
   localparam int         ACK_BIT_IDX       = 8;
   localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;
   localparam logic       RW_WRITE          = 1'b0;
   localparam logic       RW_READ           = 1'b1;

   // The general-call address is never claimed, even if it were configured as our own.
   function automatic logic is_own_addr(input logic [6:0] addr, input logic [6:0] own);
      return (addr == own) && (addr != GENERAL_CALL_ADDR);
   endfunction

endpackage

// File: rtl/i2c_target_regs_bus_sync.sv
// Synchronizes SCL/SDA into the system clock domain and derives bus edges
// plus START/STOP conditions from the synchronized values.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic system_clock,
   input  logic reset_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic                   scl_now_s;
   logic                   sda_now_s;

   // Idle bus reads high, so the chain resets to 1 to avoid phantom edges.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q[0] <= scl_i;
         sda_sync_q[0] <= sda_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_sync_q[i] <= scl_sync_q[i-1];
            sda_sync_q[i] <= sda_sync_q[i-1];
         end
         scl_prev_q <= scl_now_s;
         sda_prev_q <= sda_now_s;
      end
   end

   assign scl_now_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_now_s = sda_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_now_s;
   assign scl_rise  = scl_now_s & ~scl_prev_q;
   assign scl_fall  = ~scl_now_s & scl_prev_q;
   assign start_det = scl_now_s & scl_prev_q & sda_prev_q & ~sda_now_s;
   assign stop_det  = scl_now_s & scl_prev_q & ~sda_prev_q & sda_now_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte register file and auto-incrementing pointer.
// SDA is open-drain and only ever changes a fixed hold time after SCL falls.
module i2c_target_regs
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         NUM_REGS    = 16,
   parameter int         HOLD_CYC    = 2,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                        system_clock,
   input  logic                        reset_n,
   input  logic                        scl_i,
   input  logic                        sda_i,
   output logic                        sda_oe,
   output logic                        wr_valid,
   output logic [$clog2(NUM_REGS)-1:0] wr_addr,
   output logic [7:0]                  wr_data,
   output logic                        busy
);

   localparam int PW = $clog2(NUM_REGS);
   localparam int HW = $clog2(HOLD_CYC + 2);

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;
   logic sda_s;

   i2c_bus_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .system_clock(system_clock),
      .reset_n     (reset_n),
      .scl_i       (scl_i),
      .sda_i       (sda_i),
      .scl_rise    (scl_rise),
      .scl_fall    (scl_fall),
      .start_det   (start_det),
      .stop_det    (stop_det),
      .sda_s       (sda_s)
   );

   state_e          state_q;
   logic [3:0]      bit_cnt_q;
   logic [7:0]      shift_q;
   logic            rw_q;
   logic [PW-1:0]   ptr_q;
   logic [7:0]      regs_q [NUM_REGS];
   logic            oe_pend_q;
   logic [HW-1:0]   hold_cnt_q;
   logic            sda_oe_q;
   logic            wr_valid_q;
   logic [PW-1:0]   wr_addr_q;
   logic [7:0]      wr_data_q;
   logic            busy_q;

   logic [7:0]      rx_byte_s;
   logic [PW-1:0]   ptr_inc_s;
   logic            last_bit_s;
   logic            oe_d;

   // SDA level wanted for the bit that begins at the next SCL low phase.
   always_comb begin
      rx_byte_s  = {shift_q[6:0], sda_s};
      ptr_inc_s  = ptr_q + PW'(1);
      last_bit_s = (bit_cnt_q == 4'(BITS_PER_BYTE - 1));
      oe_d       = 1'b0;
      case (state_q)
         ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: oe_d = 1'b1;
         ST_RDATA:                              oe_d = ~shift_q[7];
         default:                               oe_d = 1'b0;
      endcase
   end

   // Protocol FSM, register file, pointer and delayed SDA driver.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         rw_q       <= RW_WRITE;
         ptr_q      <= '0;
         oe_pend_q  <= 1'b0;
         hold_cnt_q <= '0;
         sda_oe_q   <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         wr_valid_q <= 1'b0;
         if (start_det) begin
            state_q    <= ST_ADDR;
            bit_cnt_q  <= 4'd0;
            busy_q     <= 1'b1;
            sda_oe_q   <= 1'b0;
            oe_pend_q  <= 1'b0;
            hold_cnt_q <= '0;
         end else if (stop_det) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            oe_pend_q  <= 1'b0;
            hold_cnt_q <= '0;
         end else begin
            if (scl_rise) begin
               case (state_q)
                  ST_ADDR: begin
                     shift_q <= rx_byte_s;
                     if (last_bit_s) begin
                        bit_cnt_q <= 4'(ACK_BIT_IDX);
                        rw_q      <= rx_byte_s[0];
                        state_q   <= is_own_addr(rx_byte_s[7:1], TARGET_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
                  ST_ADDR_ACK: begin
                     bit_cnt_q <= 4'd0;
                     if (rw_q == RW_READ) begin
                        shift_q <= regs_q[ptr_q];
                        state_q <= ST_RDATA;
                     end else begin
                        state_q <= ST_PTR;
                     end
                  end
                  ST_PTR: begin
                     shift_q <= rx_byte_s;
                     if (last_bit_s) begin
                        bit_cnt_q <= 4'(ACK_BIT_IDX);
                        ptr_q     <= rx_byte_s[PW-1:0];
                        state_q   <= ST_PTR_ACK;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
                  ST_PTR_ACK, ST_WDATA_ACK: begin
                     bit_cnt_q <= 4'd0;
                     state_q   <= ST_WDATA;
                  end
                  ST_WDATA: begin
                     shift_q <= rx_byte_s;
                     if (last_bit_s) begin
                        bit_cnt_q     <= 4'(ACK_BIT_IDX);
                        regs_q[ptr_q] <= rx_byte_s;
                        wr_valid_q    <= 1'b1;
                        wr_addr_q     <= ptr_q;
                        wr_data_q     <= rx_byte_s;
                        ptr_q         <= ptr_inc_s;
                        state_q       <= ST_WDATA_ACK;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
                  ST_RDATA: begin
                     shift_q <= {shift_q[6:0], 1'b0};
                     if (last_bit_s) begin
                        bit_cnt_q <= 4'(ACK_BIT_IDX);
                        state_q   <= ST_RACK;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
                  ST_RACK: begin
                     bit_cnt_q <= 4'd0;
                     ptr_q     <= ptr_inc_s;
                     if (!sda_s) begin
                        shift_q <= regs_q[ptr_inc_s];
                        state_q <= ST_RDATA;
                     end else begin
                        state_q <= ST_IGNORE;
                     end
                  end
                  default: begin
                     state_q <= state_q;
                  end
               endcase
            end
            // The new SDA level is applied only after the hold delay, so it never moves while SCL is high.
            if (scl_fall) begin
               if (HOLD_CYC == 0) begin
                  sda_oe_q <= oe_d;
               end else begin
                  oe_pend_q  <= oe_d;
                  hold_cnt_q <= HW'(HOLD_CYC);
               end
            end else if (hold_cnt_q != '0) begin
               hold_cnt_q <= hold_cnt_q - HW'(1);
               if (hold_cnt_q == HW'(1)) begin
                  sda_oe_q <= oe_pend_q;
               end
            end
         end
      end
   end

   assign sda_oe   = sda_oe_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller, table vectors,
// directed corner sequences and random traffic against a register-file model.
module tb_i2c_target_regs;

   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic       wr_valid;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   logic [11:0] wr_seen[$];
   logic [11:0] exp_wr[$];
   logic [7:0]  m_regs[16];
   int          m_ptr = 0;

   int   oe_viol = 0;
   logic oe_prev = 1'b0;
   logic scl_prev = 1'b1;

   typedef struct {
      logic [7:0] dev;
      logic [7:0] ptr;
      logic [7:0] data;
      logic       exp_ack;
      logic [3:0] exp_waddr;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   assign sda_bus = sda_drv & ~sda_oe;

   i2c_target_regs dut (
      .system_clock(clk),
      .reset_n     (rst_n),
      .scl_i       (scl_drv),
      .sda_i       (sda_bus),
      .sda_oe      (sda_oe),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy)
   );

   always @(negedge clk) begin
      if (rst_n && wr_valid) wr_seen.push_back({wr_addr, wr_data});
   end

   always @(negedge clk) begin
      if (rst_n && scl_drv && scl_prev && (sda_oe != oe_prev)) oe_viol <= oe_viol + 1;
      oe_prev  <= sda_oe;
      scl_prev <= scl_drv;
   end

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; wait_q();
      scl_drv = 1'b1; wait_q();
      sda_drv = 1'b0; wait_q();
      scl_drv = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; wait_q();
      scl_drv = 1'b1; wait_q();
      sda_drv = 1'b1; wait_q();
   endtask

   task automatic i2c_bit(input logic b, output logic s);
      sda_drv = b;    wait_q();
      scl_drv = 1'b1; wait_q();
      s = sda_bus;    wait_q();
      scl_drv = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
      i2c_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         i2c_bit(1'b1, s);
         d[i] = s;
      end
      i2c_bit(~ack, s);
   endtask

   task automatic check_wr();
      check("wr_count", wr_seen.size(), exp_wr.size());
      for (int k = 0; k < exp_wr.size() && k < wr_seen.size(); k++)
         check("wr_event", int'(wr_seen[k]), int'(exp_wr[k]));
      wr_seen.delete();
      exp_wr.delete();
   endtask

   // START, device byte, pointer, n data bytes, STOP; model predicts ACKs and writes.
   task automatic tx_write(input logic [7:0] dev, input logic [7:0] p, input int n, input logic [23:0] dat);
      logic ack;
      logic match;
      logic [7:0] b;
      match = (dev == 8'hA0);
      i2c_start();
      check("busy_start", busy, 1);
      write_byte(dev, ack);
      check("wr_addr_ack", ack, match);
      write_byte(p, ack);
      check("wr_ptr_ack", ack, match);
      if (match) m_ptr = p % 16;
      for (int k = 0; k < n; k++) begin
         b = dat[8*k +: 8];
         write_byte(b, ack);
         check("wr_data_ack", ack, match);
         if (match) begin
            m_regs[m_ptr] = b;
            exp_wr.push_back({4'(m_ptr), b});
            m_ptr = (m_ptr + 1) % 16;
         end
      end
      i2c_stop();
      check("busy_stop", busy, 0);
      check("sda_rel_stop", sda_oe, 0);
      check_wr();
   endtask

   // Current-pointer read of n bytes; last byte NACKed.
   task automatic tx_read(input logic [7:0] dev, input int n);
      logic ack;
      logic [7:0] d;
      i2c_start();
      write_byte(dev, ack);
      check("rd_addr_ack", ack, (dev == 8'hA1));
      if (dev == 8'hA1) begin
         for (int k = 0; k < n; k++) begin
            read_byte(k < n - 1, d);
            check("rd_data", d, m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % 16;
         end
      end
      i2c_stop();
      check_wr();
   endtask

   // Set pointer, repeated START, read n bytes.
   task automatic tx_ptr_read(input logic [7:0] p, input int n);
      logic ack;
      logic [7:0] d;
      i2c_start();
      write_byte(8'hA0, ack);
      check("pr_addr_ack", ack, 1);
      write_byte(p, ack);
      check("pr_ptr_ack", ack, 1);
      m_ptr = p % 16;
      i2c_start();
      write_byte(8'hA1, ack);
      check("pr_raddr_ack", ack, 1);
      for (int k = 0; k < n; k++) begin
         read_byte(k < n - 1, d);
         check("pr_data", d, m_regs[m_ptr]);
         m_ptr = (m_ptr + 1) % 16;
      end
      check("sda_rel_nack", sda_oe, 0);
      i2c_stop();
      check_wr();
   endtask

   initial begin
      logic ack;
      logic s;
      logic [7:0] dev;
      int n;

      vecs[0] = '{8'hA0, 8'h05, 8'h5A, 1'b1, 4'h5};
      vecs[1] = '{8'hA0, 8'h06, 8'h6B, 1'b1, 4'h6};
      vecs[2] = '{8'hA2, 8'h05, 8'h33, 1'b0, 4'h0};
      vecs[3] = '{8'h00, 8'h07, 8'h44, 1'b0, 4'h0};
      vecs[4] = '{8'hA0, 8'h1F, 8'h55, 1'b1, 4'hF};
      vecs[5] = '{8'hA0, 8'h0C, 8'h66, 1'b1, 4'hC};
      vecs[6] = '{8'hA0, 8'h80, 8'h77, 1'b1, 4'h0};
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

      repeat (5) @(posedge clk);
      #1;
      check("rst_sda_oe", sda_oe, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_q();

      // SCL pulses while idle must be ignored.
      for (int i = 0; i < 3; i++) begin
         scl_drv = 1'b0; wait_q();
         scl_drv = 1'b1; wait_q();
      end
      check("idle_busy", busy, 0);
      check("idle_sda", sda_oe, 0);

      for (int v = 0; v < 7; v++) begin
         i2c_start();
         write_byte(vecs[v].dev, ack);
         check("vec_addr_ack", ack, vecs[v].exp_ack);
         write_byte(vecs[v].ptr, ack);
         check("vec_ptr_ack", ack, vecs[v].exp_ack);
         write_byte(vecs[v].data, ack);
         check("vec_data_ack", ack, vecs[v].exp_ack);
         i2c_stop();
         if (vecs[v].exp_ack) begin
            check("vec_wr_count", wr_seen.size(), 1);
            if (wr_seen.size() > 0) begin
               check("vec_wr_addr", wr_seen[0][11:8], vecs[v].exp_waddr);
               check("vec_wr_data", wr_seen[0][7:0], vecs[v].data);
            end
            m_regs[vecs[v].exp_waddr] = vecs[v].data;
            m_ptr = (vecs[v].exp_waddr + 1) % 16;
         end else begin
            check("vec_wr_count", wr_seen.size(), 0);
         end
         wr_seen.delete();
      end

      // Write burst, then write/read with repeated START leaving pointer at 5.
      tx_write(8'hA0, 8'h03, 2, 24'h002211);
      tx_ptr_read(8'h03, 2);
      check("ptr_after_read", m_ptr, 5);
      tx_read(8'hA1, 1);

      // Wrap-around on write and masked pointer on read.
      tx_write(8'hA0, 8'h0F, 2, 24'h00BBAA);
      tx_ptr_read(8'h1F, 1);

      // STOP mid-byte aborts the partial byte.
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h02, ack);
      for (int i = 0; i < 4; i++) i2c_bit(1'b1, s);
      i2c_stop();
      check("abort_wr_count", wr_seen.size(), 0);
      check("abort_sda", sda_oe, 0);
      check("abort_busy", busy, 0);
      m_ptr = 2;
      tx_read(8'hA1, 1);

      // Repeated START mid-byte: next address byte is ACKed.
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h02, ack);
      for (int i = 0; i < 4; i++) i2c_bit(1'b0, s);
      i2c_start();
      write_byte(8'hA0, ack);
      check("sr_abort_ack", ack, 1);
      write_byte(8'h09, ack);
      check("sr_abort_ptr_ack", ack, 1);
      i2c_stop();
      m_ptr = 9;
      check_wr();

      // Reset while the target is driving a 0 data bit.
      tx_write(8'hA0, 8'h08, 1, 24'h000012);
      i2c_start();
      write_byte(8'hA0, ack);
      write_byte(8'h08, ack);
      i2c_start();
      write_byte(8'hA1, ack);
      check("rrst_addr_ack", ack, 1);
      check("rrst_drive0", sda_oe, 1);
      #3 rst_n = 1'b0;
      #1 check("rrst_async_release", sda_oe, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rrst_busy", busy, 0);
      sda_drv = 1'b1;
      scl_drv = 1'b1;
      wait_q();
      rst_n = 1'b1;
      wait_q();
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_ptr = 0;
      tx_read(8'hA1, 2);
      tx_ptr_read(8'h08, 1);

      // Random traffic against the model.
      for (int t = 0; t < 20; t++) begin
         n = $urandom_range(1, 3);
         case ($urandom_range(0, 3))
            0: tx_write(8'hA0, 8'($urandom_range(0, 255)), n, 24'($urandom));
            1: tx_read(8'hA1, n);
            2: tx_ptr_read(8'($urandom_range(0, 255)), n);
            default: begin
               dev = 8'($urandom_range(0, 255));
               while (dev[7:1] == 7'h50) dev = 8'($urandom_range(0, 255));
               tx_write(dev, 8'($urandom_range(0, 255)), n, 24'($urandom));
            end
         endcase
      end

      check("sda_stable_scl_high", oe_viol, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
